// File: rtl/reg_file_sb.sv
// Scoreboarded register file for the pipelined Beta decode stage: pending counters
// per register, hardware clear after reset. Optional write-through: RF_BYPASS_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_CLEAR | zeroing mem[clr_idx] once per cycle; inputs ignored; stall=1
// ST_READY | normal operation: reads, write-back, issue/scoreboard updates
module reg_file_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 31,
   parameter int CNT_W    = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_RD-1:0]          rd_en,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   input  logic                       we,
   input  logic [ADDR_W-1:0]          wa,
   input  logic [DATA_W-1:0]          wd,
   input  logic                       wb_long,
   input  logic                       iss_valid,
   input  logic [ADDR_W-1:0]          iss_rc,
   input  logic                       iss_long,
   input  logic                       flush,
   output logic                       stall,
   output logic                       iss_full,
   output logic                       init_busy,
   output logic                       sb_err
);

   localparam int                NREGS   = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_REG);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(NREGS-1);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   clr_idx, clr_idx_nxt;
   logic                ready;
   logic                wr_en;
   logic                iss_ok;
   logic                spurious;
   logic [NUM_RD-1:0]   port_haz;
   logic [NREGS-1:0]    inc_v, dec_v;
   logic [DATA_W-1:0]   mem [NREGS];
   logic [CNT_W-1:0]    cnt [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_CLEAR;
         clr_idx <= '0;
      end else begin
         state   <= state_nxt;
         clr_idx <= clr_idx_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_idx_nxt = clr_idx;
      case (state)
         ST_CLEAR: begin
            clr_idx_nxt = clr_idx + ADDR_W'(1);
            if (clr_idx == LAST_A) state_nxt = ST_READY;
         end
         default: state_nxt = ST_READY;
      endcase
   end

   assign ready     = (state == ST_READY);
   assign init_busy = ~ready;
   assign wr_en     = ready && we && (wa != ZERO_A);

   // Storage has no reset; the clear FSM owns the write port until READY.
   always_ff @(posedge clk) begin
      if (!ready)     mem[clr_idx] <= '0;
      else if (wr_en) mem[wa]      <= wd;
   end

   for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              fwd;
      logic              pend;
      assign ra   = rd_addr[gi*ADDR_W +: ADDR_W];
      assign fwd  = ready && we && (wa == ra);
      assign pend = (cnt[ra] != '0);
`ifdef RF_BYPASS_EN
      assign rd_data[gi*DATA_W +: DATA_W] = (ra == ZERO_A) ? '0 : (fwd ? wd : mem[ra]);
      // The completing write-back of the last outstanding load releases the hazard.
      assign port_haz[gi] = rd_en[gi] && (ra != ZERO_A) && pend &&
                            !(fwd && wb_long && (cnt[ra] == CNT_ONE));
`else
      assign rd_data[gi*DATA_W +: DATA_W] = (ra == ZERO_A) ? '0 : mem[ra];
      // No write-through: a read of the register being written must wait a cycle.
      assign port_haz[gi] = rd_en[gi] && (ra != ZERO_A) && (pend || fwd);
`endif
   end

   assign iss_full = ready && iss_valid && iss_long && (iss_rc != ZERO_A) &&
                     (cnt[iss_rc] == CNT_MAX);
   assign stall    = !ready || iss_full || (|port_haz);
   assign iss_ok   = iss_valid && iss_long && (iss_rc != ZERO_A) && !iss_full && !stall;
   assign spurious = we && wb_long && (cnt[wa] == '0);

   always_comb begin
      inc_v = '0;
      dec_v = '0;
      for (int r = 0; r < NREGS; r++) begin
         inc_v[r] = iss_ok && (iss_rc == ADDR_W'(r));
         dec_v[r] = we && wb_long && (wa == ADDR_W'(r)) && (cnt[r] != '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
         sb_err <= 1'b0;
      end else if (ready) begin
         if (spurious) sb_err <= 1'b1;
         for (int r = 0; r < NREGS; r++) begin
            if (flush)                     cnt[r] <= '0;
            else if (inc_v[r] && !dec_v[r]) cnt[r] <= cnt[r] + CNT_ONE;
            else if (dec_v[r] && !inc_v[r]) cnt[r] <= cnt[r] - CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios then random traffic,
// checked each cycle against an array-based scoreboard model.
module tb_reg_file_sb;

   logic        clk;
   logic        rst_n;
   logic [1:0]  rd_en;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic        wb_long;
   logic        iss_valid;
   logic [4:0]  iss_rc;
   logic        iss_long;
   logic        flush;
   logic        stall;
   logic        iss_full;
   logic        init_busy;
   logic        sb_err;

   int          nvec = 0;
   int          nerr = 0;

   logic [31:0] mem_m [32];
   int          cnt_m [32];
   bit          err_m;
   int          clr_left;

   reg_file_sb dut (
      .clk(clk), .rst_n(rst_n),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .we(we), .wa(wa), .wd(wd), .wb_long(wb_long),
      .iss_valid(iss_valid), .iss_rc(iss_rc), .iss_long(iss_long),
      .flush(flush), .stall(stall), .iss_full(iss_full),
      .init_busy(init_busy), .sb_err(sb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rd_en = 2'b00; rd_addr = '0; we = 0; wa = '0; wd = '0; wb_long = 0;
      iss_valid = 0; iss_rc = '0; iss_long = 0; flush = 0;
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin cnt_m[r] = 0; mem_m[r] = '0; end
      err_m = 0;
      clr_left = 32;
   endtask

   task automatic rd(input int port, input logic [4:0] a);
      rd_en[port] = 1'b1;
      rd_addr[port*5 +: 5] = a;
   endtask

   // Check outputs for the inputs already driven, then advance the model and the clock.
   task automatic cycle();
      bit rdy, full_e, stall_e, inc, dec;
      logic [4:0]  a;
      logic [31:0] exp_d;
      #2;
      rdy     = rst_n && (clr_left == 0);
      full_e  = rdy && iss_valid && iss_long && iss_rc != 5'd31 && cnt_m[iss_rc] == 3;
      stall_e = !rdy || full_e;
      for (int i = 0; i < 2; i++) begin
         a = rd_addr[i*5 +: 5];
         if (rd_en[i] && a != 5'd31) begin
`ifdef RF_BYPASS_EN
            if (cnt_m[a] > 0 && !(rdy && we && wb_long && wa == a && cnt_m[a] == 1)) stall_e = 1;
`else
            if (cnt_m[a] > 0 || (rdy && we && wa == a)) stall_e = 1;
`endif
         end
      end
      check("init_busy", {63'd0, init_busy}, {63'd0, !rdy});
      check("stall",     {63'd0, stall},     {63'd0, stall_e});
      check("iss_full",  {63'd0, iss_full},  {63'd0, full_e});
      check("sb_err",    {63'd0, sb_err},    {63'd0, err_m});
      if (rdy) begin
         for (int i = 0; i < 2; i++) begin
            a = rd_addr[i*5 +: 5];
            if (rd_en[i]) begin
               if (a == 5'd31) exp_d = '0;
`ifdef RF_BYPASS_EN
               else if (we && wa == a) exp_d = wd;
`endif
               else exp_d = mem_m[a];
               check($sformatf("rd_data%0d[r%0d]", i, a), {32'd0, rd_data[i*32 +: 32]}, {32'd0, exp_d});
            end
         end
         if (we && wb_long && cnt_m[wa] == 0) err_m = 1;
         if (flush) begin
            for (int r = 0; r < 32; r++) cnt_m[r] = 0;
         end else begin
            inc = iss_valid && iss_long && iss_rc != 5'd31 && !full_e && !stall_e;
            dec = we && wb_long && cnt_m[wa] > 0;
            if (inc) cnt_m[iss_rc] = cnt_m[iss_rc] + 1;
            if (dec) cnt_m[wa] = cnt_m[wa] - 1;
         end
         if (we && wa != 5'd31) mem_m[wa] = wd;
      end else if (rst_n && clr_left > 0) begin
         clr_left = clr_left - 1;
      end
      @(posedge clk); #1;
   endtask

   function automatic logic [4:0] pick();
      if ($urandom_range(0, 5) == 0) return 5'd31;
      return 5'($urandom_range(0, 7));
   endfunction

   initial begin
      idle();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk); #1;
      cycle(); cycle();

      // Release reset: 32 clear cycles; a write during clear must be dropped.
      rst_n = 1'b1;
      for (int n = 0; n < 32; n++) begin
         idle();
         if (n == 3) begin we = 1; wa = 5'd3; wd = 32'hDEAD; end
         if (n == 5) begin iss_valid = 1; iss_long = 1; iss_rc = 5'd4; flush = 1; end
         cycle();
      end
      check("busy_after_clear", {63'd0, init_busy}, 64'd0);

      for (int a = 0; a < 32; a++) begin
         idle(); rd(0, 5'(a)); rd(1, 5'(31 - a)); cycle();
      end

      // Long load to R5, then dependent read.
      idle(); iss_valid = 1; iss_long = 1; iss_rc = 5'd5; cycle();
      idle(); rd(0, 5'd5); cycle();
      idle(); rd(0, 5'd5); cycle();
      idle(); rd(0, 5'd5); we = 1; wb_long = 1; wa = 5'd5; wd = 32'h1234; cycle();
      idle(); rd(0, 5'd5); rd(1, 5'd5); cycle();
      check("r5_released", {63'd0, stall}, 64'd0);

      // Saturate R7, fourth issue rejected, three write-backs drain it.
      for (int n = 0; n < 4; n++) begin
         idle(); iss_valid = 1; iss_long = 1; iss_rc = 5'd7; cycle();
      end
      idle(); iss_valid = 1; iss_long = 1; iss_rc = 5'd7; #2;
      check("r7_full", {63'd0, iss_full}, 64'd1);
      #1; idle(); #1;
      for (int n = 0; n < 3; n++) begin
         idle(); rd(1, 5'd7); we = 1; wb_long = 1; wa = 5'd7; wd = 32'h700 + n; cycle();
      end
      idle(); rd(1, 5'd7); cycle();

      // Same-cycle issue and completing write-back on R9 leave it pending.
      idle(); iss_valid = 1; iss_long = 1; iss_rc = 5'd9; cycle();
      idle(); iss_valid = 1; iss_long = 1; iss_rc = 5'd9;
      we = 1; wb_long = 1; wa = 5'd9; wd = 32'h99; cycle();
      idle(); rd(0, 5'd9); cycle();
      check("r9_pending", {63'd0, stall}, 64'd1);
      idle(); we = 1; wb_long = 1; wa = 5'd9; wd = 32'h999; cycle();
      idle(); rd(0, 5'd9); cycle();

      // Flush beats a simultaneous issue; later wb_long on R2 is spurious.
      idle(); iss_valid = 1; iss_long = 1; iss_rc = 5'd2; cycle();
      idle(); iss_valid = 1; iss_long = 1; iss_rc = 5'd2; cycle();
      idle(); iss_valid = 1; iss_long = 1; iss_rc = 5'd2; flush = 1;
      we = 1; wa = 5'd6; wd = 32'h6666; cycle();
      idle(); rd(0, 5'd2); rd(1, 5'd6); cycle();
      idle(); we = 1; wb_long = 1; wa = 5'd2; wd = 32'h22; cycle();
      idle(); cycle();
      check("sb_err_set", {63'd0, sb_err}, 64'd1);

      // Hardwired zero register.
      idle(); we = 1; wa = 5'd31; wd = 32'hFFFF_FFFF; cycle();
      idle(); iss_valid = 1; iss_long = 1; iss_rc = 5'd31; rd(0, 5'd31); cycle();
      idle(); rd(0, 5'd31); rd(1, 5'd31); cycle();

      // Reset mid-clear restarts the full clear sequence.
      rst_n = 1'b0; model_reset(); idle(); cycle();
      rst_n = 1'b1;
      for (int n = 0; n < 10; n++) begin idle(); cycle(); end
      rst_n = 1'b0; model_reset(); cycle();
      rst_n = 1'b1;
      for (int n = 0; n < 33; n++) begin idle(); rd(0, 5'(n)); cycle(); end

      // Random traffic.
      for (int n = 0; n < 800; n++) begin
         idle();
         rd_en   = 2'($urandom_range(0, 3));
         rd_addr = {pick(), pick()};
         if ($urandom_range(0, 2) == 0) begin
            we = 1; wa = pick(); wd = $urandom;
            if (cnt_m[wa] > 0) wb_long = 1'($urandom_range(0, 1));
            else               wb_long = ($urandom_range(0, 63) == 0);
         end
         if ($urandom_range(0, 1) == 1) begin
            iss_valid = 1; iss_rc = pick(); iss_long = ($urandom_range(0, 3) != 0);
         end
         flush = ($urandom_range(0, 39) == 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
